// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM between two requesters: round-robin write and read
// arbitration, tagged read returns, and a zero-fill clear engine after reset or on command.
module bram_port_arbiter #(
  parameter int N_ADDR     = 256,
  parameter int DATA_WIDTH = 16,
  localparam int AW        = $clog2(N_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  wreq0,
  input  logic                  wreq1,
  input  logic [AW-1:0]         wadd0,
  input  logic [AW-1:0]         wadd1,
  input  logic [DATA_WIDTH-1:0] win0,
  input  logic [DATA_WIDTH-1:0] win1,
  output logic                  wgnt0,
  output logic                  wgnt1,
  input  logic                  rreq0,
  input  logic                  rreq1,
  input  logic [AW-1:0]         radd0,
  input  logic [AW-1:0]         radd1,
  output logic                  rgnt0,
  output logic                  rgnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_wen,
  output logic [AW-1:0]         mem_wadd,
  output logic [DATA_WIDTH-1:0] mem_win,
  output logic                  mem_ren,
  output logic [AW-1:0]         mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          wr_ptr, wr_ptr_nxt;
  logic          rd_ptr, rd_ptr_nxt;
  logic          rvld0_p1, rvld1_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rvld0_p1 <= 1'b0;
      rvld1_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rvld0_p1 <= rgnt0 & rreq0;
      rvld1_p1 <= rgnt1 & rreq1;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    busy        = 1'b0;
    wgnt0       = 1'b0;
    wgnt1       = 1'b0;
    rgnt0       = 1'b0;
    rgnt1       = 1'b0;
    mem_wen     = 1'b0;
    mem_wadd    = '0;
    mem_win     = '0;
    mem_ren     = 1'b0;
    mem_radd    = '0;
    case (state)
      CLEAR: begin
        busy        = 1'b1;
        mem_wen     = 1'b1;
        mem_wadd    = clr_cnt;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(N_ADDR - 1)) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        // On contention the pointer picks the winner; a lone requester always wins.
        wgnt0 = wreq0 & (~wreq1 | ~wr_ptr);
        wgnt1 = wreq1 & (~wreq0 |  wr_ptr);
        rgnt0 = rreq0 & (~rreq1 | ~rd_ptr);
        rgnt1 = rreq1 & (~rreq0 |  rd_ptr);

        mem_wen = wgnt0 | wgnt1;
        if (wgnt0) begin
          mem_wadd   = wadd0;
          mem_win    = win0;
          wr_ptr_nxt = 1'b1;
        end else if (wgnt1) begin
          mem_wadd   = wadd1;
          mem_win    = win1;
          wr_ptr_nxt = 1'b0;
        end

        mem_ren = rgnt0 | rgnt1;
        if (rgnt0) begin
          mem_radd   = radd0;
          rd_ptr_nxt = 1'b1;
        end else if (rgnt1) begin
          mem_radd   = radd1;
          rd_ptr_nxt = 1'b0;
        end

        if (clear) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // p1: BRAM read data returns one cycle after acceptance, steered by the tag
  assign rvalid0 = rvld0_p1;
  assign rvalid1 = rvld1_p1;
  assign rdata0  = rvld0_p1 ? mem_rdata : '0;
  assign rdata1  = rvld1_p1 ? mem_rdata : '0;

endmodule
